// File: rtl/wave_xfade_switch.sv
// Click-free waveform source switcher.
// Instead of switching sources instantly, the current source is faded to
// zero, the source index is swapped at zero gain, and the new source is
// faded back in. The gain moves one step per sample_req strobe.
// Optional build macro: XFADE_SOFT_START_EN. When it is defined, the switcher
// leaves reset fading in from silence instead of starting at full gain.
module wave_xfade_switch #(
  parameter int RAMP_SHIFT = 6,
  parameter int DATA_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_req,
  input  logic [2:0]        wave_sel,
  input  logic [DATA_W-1:0] sine_in,
  input  logic [DATA_W-1:0] square_in,
  input  logic [DATA_W-1:0] triangle_in,
  input  logic [DATA_W-1:0] sawtooth_in,
  input  logic [DATA_W-1:0] ecg_in,
  output logic [DATA_W-1:0] audio_output,
  output logic [2:0]        cur_src,
  output logic              busy
);

  localparam int GW = RAMP_SHIFT + 1;
  localparam int PW = DATA_W + RAMP_SHIFT + 2;
  localparam logic [GW-1:0] GMAX    = {1'b1, {RAMP_SHIFT{1'b0}}};
  localparam logic [GW-1:0] GMAX_M1 = {1'b0, {RAMP_SHIFT{1'b1}}};
  localparam logic [GW-1:0] GONE    = {{RAMP_SHIFT{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, FADE_OUT, FADE_IN} state_t;

  state_t            state_q, state_d;
  logic [GW-1:0]     gain_q, gain_d;
  logic [2:0]        cur_src_q, cur_src_d;
  logic [DATA_W-1:0] audio_q, sample_d;
  logic [2:0]        sync1_q, sync2_q;
  logic [2:0]        target;

  logic signed [DATA_W-1:0] src_s;
  logic signed [GW:0]       gain_s;
  logic signed [PW-1:0]     prod;

  // Two-flop synchronizer for the switch input; it runs every clock so the
  // select is settled by the time a strobe looks at it.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 3'b000;
      sync2_q <= 3'b000;
    end else begin
      sync1_q <= wave_sel;
      sync2_q <= sync1_q;
    end
  end

  // Map the switch pattern onto a source index; unknown patterns fall back to sine.
  always_comb begin
    target = 3'd0;
    case (sync2_q)
      3'b000:  target = 3'd0;
      3'b001:  target = 3'd1;
      3'b011:  target = 3'd2;
      3'b110:  target = 3'd3;
      3'b010:  target = 3'd4;
      default: target = 3'd0;
    endcase
  end

  // State register: state, gain, source index and output sample advance only on strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
`ifdef XFADE_SOFT_START_EN
      state_q <= FADE_IN;
      gain_q  <= '0;
`else
      state_q <= IDLE;
      gain_q  <= GMAX;
`endif
      cur_src_q <= 3'd0;
      audio_q   <= '0;
    end else if (sample_req) begin
      state_q   <= state_d;
      gain_q    <= gain_d;
      cur_src_q <= cur_src_d;
      audio_q   <= sample_d;
    end
  end

  // Next-state logic for the fade-out / swap / fade-in ramp.
  always_comb begin
    state_d   = state_q;
    gain_d    = gain_q;
    cur_src_d = cur_src_q;
    case (state_q)
      IDLE: begin
        if (target != cur_src_q) begin
          state_d = FADE_OUT;
          gain_d  = GMAX_M1;
        end
      end
      FADE_OUT: begin
        if (target == cur_src_q) begin
          state_d = FADE_IN;
          gain_d  = gain_q + GONE;
        end else if (gain_q == '0) begin
          cur_src_d = target;
          state_d   = FADE_IN;
          gain_d    = GONE;
        end else begin
          gain_d = gain_q - GONE;
        end
      end
      FADE_IN: begin
        // Gain can only be zero here right after a soft-start reset; clamp it
        // so a select change at that moment cannot wrap the gain.
        if (target != cur_src_q) begin
          state_d = FADE_OUT;
          gain_d  = (gain_q == '0) ? '0 : gain_q - GONE;
        end else if (gain_q == GMAX) begin
          state_d = IDLE;
        end else begin
          gain_d = gain_q + GONE;
        end
      end
      default: begin
        state_d = IDLE;
        gain_d  = GMAX;
      end
    endcase
  end

  // Output logic: select the active source and scale it by the pre-step gain.
  always_comb begin
    src_s = $signed(sine_in);
    case (cur_src_q)
      3'd0:    src_s = $signed(sine_in);
      3'd1:    src_s = $signed(square_in);
      3'd2:    src_s = $signed(triangle_in);
      3'd3:    src_s = $signed(sawtooth_in);
      3'd4:    src_s = $signed(ecg_in);
      default: src_s = $signed(sine_in);
    endcase
    gain_s       = $signed({1'b0, gain_q});
    prod         = PW'(src_s) * PW'(gain_s);
    sample_d     = DATA_W'(prod >>> RAMP_SHIFT);
    busy         = (state_q != IDLE);
    cur_src      = cur_src_q;
    audio_output = audio_q;
  end

endmodule
